// File: rtl/br_pred_table.sv
// Branch target table with saturating counters; optional return-address stack when BP_RAS_EN is defined.
// Latency: lookup is combinational, updates land on the next edge; never backpressures, always accepts.
module br_pred_table #(
  parameter int ENTRIES   = 16,
  parameter int CTR_W     = 2,
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              lk_en,
  input  logic [ADDR_W-1:0] lk_pc,
  input  logic              lk_call,
  input  logic              lk_ret,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispred,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] tgt;
    logic [CTR_W-1:0]  ctr;
  } entry_t;

  // Valid bits live apart from the entries so flush can clear them while keeping history.
  logic [ENTRIES-1:0] valid_q;
  entry_t             tbl_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  entry_t           lk_ent, upd_ent;
  logic             tbl_hit, upd_hit;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign lk_ent  = tbl_q[lk_idx];
  assign upd_ent = tbl_q[upd_idx];
  assign tbl_hit = lk_en & valid_q[lk_idx] & (lk_ent.tag == lk_tag);
  assign upd_hit = valid_q[upd_idx] & (upd_ent.tag == upd_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '{tag: '0, tgt: '0, ctr: CTR_WNT};
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (upd_en) begin
      if (upd_hit) begin
        if (upd_taken) begin
          tbl_q[upd_idx].tgt <= upd_target;
          if (upd_ent.ctr != CTR_MAX) tbl_q[upd_idx].ctr <= upd_ent.ctr + 1'b1;
        end else if (upd_ent.ctr != '0) begin
          tbl_q[upd_idx].ctr <= upd_ent.ctr - 1'b1;
        end
      end else begin
        valid_q[upd_idx] <= 1'b1;
        tbl_q[upd_idx]   <= '{tag: upd_tag, tgt: upd_target,
                              ctr: (upd_taken ? CTR_WT : CTR_WNT)};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups <= '0;
      stat_mispred <= '0;
    end else begin
      if (lk_en) stat_lookups <= stat_lookups + 32'd1;
      if (upd_en && upd_mispred) stat_mispred <= stat_mispred + 32'd1;
    end
  end

`ifdef BP_RAS_EN
  localparam int RP_W = $clog2(RAS_DEPTH);
  localparam logic [RP_W:0] RAS_FULL = (RP_W+1)'(RAS_DEPTH);

  // ras_ptr is the next free slot; the top of stack sits one below it.
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [RP_W-1:0]   ras_ptr, top_ptr;
  logic [RP_W:0]     ras_cnt;
  logic              ras_hit, ras_push;
  logic [ADDR_W-1:0] ret_addr;

  assign top_ptr  = ras_ptr - 1'b1;
  assign ras_hit  = lk_en & lk_ret & (ras_cnt != '0);
  assign ras_push = lk_en & lk_call;
  assign ret_addr = lk_pc + ADDR_W'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (flush) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_hit && ras_push) begin
      ras_mem[top_ptr] <= ret_addr;
    end else if (ras_hit) begin
      ras_ptr <= top_ptr;
      ras_cnt <= ras_cnt - 1'b1;
    end else if (ras_push) begin
      ras_mem[ras_ptr] <= ret_addr;
      ras_ptr          <= ras_ptr + 1'b1;
      if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    lk_hit    = tbl_hit;
    lk_taken  = tbl_hit & lk_ent.ctr[CTR_W-1];
    lk_target = tbl_hit ? lk_ent.tgt : '0;
`ifdef BP_RAS_EN
    if (ras_hit) begin
      lk_hit    = 1'b1;
      lk_taken  = 1'b1;
      lk_target = ras_mem[top_ptr];
    end
`endif
  end

  // PC byte-offset bits never index the table; call/ret only matter with the stack built in.
  logic unused_ok;
  assign unused_ok = &{1'b0, lk_pc[1:0], upd_pc[1:0], lk_call, lk_ret};

endmodule

// File: tb/tb_br_pred_table.sv
// Directed bench for br_pred_table (ENTRIES=16, CTR_W=2); stack scenario runs when BP_RAS_EN is defined.
module tb_br_pred_table;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, flush, lk_en, lk_call, lk_ret, upd_en, upd_taken, upd_mispred;
  logic [AW-1:0] lk_pc, upd_pc, upd_target, lk_target;
  logic          lk_hit, lk_taken;
  logic [31:0]   stat_lookups, stat_mispred;

  int n_chk  = 0;
  int n_pass = 0;
  int unsigned exp_lk = 0;
  int unsigned exp_mp = 0;

  always #5 clk = ~clk;

  br_pred_table #(.ENTRIES(16), .CTR_W(2), .ADDR_W(AW), .RAS_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lk_en(lk_en), .lk_pc(lk_pc), .lk_call(lk_call), .lk_ret(lk_ret),
    .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_target(lk_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred),
    .stat_lookups(stat_lookups), .stat_mispred(stat_mispred)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock edge; inputs change and outputs are sampled mid-low-phase.
  task automatic step();
    if (!rst && lk_en) exp_lk++;
    if (!rst && upd_en && upd_mispred) exp_mp++;
    @(negedge clk);
    #1;
  endtask

  task automatic look(input logic [AW-1:0] pc);
    lk_en = 1'b1;
    lk_pc = pc;
    #1;
  endtask

  task automatic upd(input logic [AW-1:0] pc, input logic t, input logic [AW-1:0] tgt, input logic mp);
    lk_en       = 1'b0;
    upd_en      = 1'b1;
    upd_pc      = pc;
    upd_taken   = t;
    upd_target  = tgt;
    upd_mispred = mp;
    step();
    upd_en      = 1'b0;
    upd_mispred = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; lk_call = 1'b0; lk_ret = 1'b0;
    upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispred = 1'b0;
    lk_en = 1'b1; lk_pc = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (stat_lookups !== 32'd0) $display("FAIL rst_lookups got %0d want 0", stat_lookups); else n_pass++;
    n_chk++; if (stat_mispred !== 32'd0) $display("FAIL rst_mispred got %0d want 0", stat_mispred); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (lk_hit !== 1'b0) $display("FAIL cold_hit got %b want 0", lk_hit); else n_pass++;
    n_chk++; if (lk_taken !== 1'b0) $display("FAIL cold_taken got %b want 0", lk_taken); else n_pass++;
    n_chk++; if (lk_target !== 32'h0) $display("FAIL cold_target got %h want 0", lk_target); else n_pass++;
    step();
    n_chk++; if (stat_lookups !== 32'd1) $display("FAIL first_lookup_count got %0d want 1", stat_lookups); else n_pass++;
    lk_en = 1'b0;
  endtask

  task automatic test_counter();
    upd(32'h100, 1'b1, 32'h80, 1'b0);             // allocate, ctr=2
    look(32'h100);
    n_chk++; if (lk_hit !== 1'b1) $display("FAIL alloc_hit got %b want 1", lk_hit); else n_pass++;
    n_chk++; if (lk_taken !== 1'b1) $display("FAIL alloc_taken got %b want 1", lk_taken); else n_pass++;
    n_chk++; if (lk_target !== 32'h80) $display("FAIL alloc_target got %h want 80", lk_target); else n_pass++;
    lk_en = 1'b0;
    #1;
    n_chk++; if ({lk_hit, lk_taken, lk_target} !== {2'b00, 32'h0}) $display("FAIL idle_outputs got %b%b_%h want 00_0", lk_hit, lk_taken, lk_target); else n_pass++;
    upd(32'h100, 1'b0, 32'h999, 1'b0);            // ctr=1, target kept
    look(32'h100);
    n_chk++; if (lk_taken !== 1'b0) $display("FAIL ctr1_taken got %b want 0", lk_taken); else n_pass++;
    n_chk++; if (lk_target !== 32'h80) $display("FAIL nt_keeps_target got %h want 80", lk_target); else n_pass++;
    upd(32'h100, 1'b0, 32'h80, 1'b0);             // ctr=0
    upd(32'h100, 1'b0, 32'h80, 1'b0);             // stays 0
    upd(32'h100, 1'b1, 32'h80, 1'b0);             // ctr=1 (would be 3->... if it wrapped)
    look(32'h100);
    n_chk++; if (lk_taken !== 1'b0) $display("FAIL sat_low_taken got %b want 0", lk_taken); else n_pass++;
    upd(32'h100, 1'b1, 32'h90, 1'b0);             // ctr=2, target 0x90
    look(32'h100);
    n_chk++; if (lk_taken !== 1'b1) $display("FAIL ctr2_taken got %b want 1", lk_taken); else n_pass++;
    n_chk++; if (lk_target !== 32'h90) $display("FAIL taken_new_target got %h want 90", lk_target); else n_pass++;
    upd(32'h100, 1'b1, 32'h90, 1'b0);             // ctr=3
    upd(32'h100, 1'b1, 32'h90, 1'b0);             // stays 3
    upd(32'h100, 1'b0, 32'h90, 1'b0);             // ctr=2
    look(32'h100);
    n_chk++; if (lk_taken !== 1'b1) $display("FAIL sat_high_taken got %b want 1", lk_taken); else n_pass++;
    lk_en = 1'b0;
  endtask

  task automatic test_alias();
    upd(32'h100, 1'b1, 32'h80, 1'b0);
    upd(32'h140, 1'b1, 32'h300, 1'b0);            // same index 0, tag 5 replaces tag 4
    look(32'h100);
    n_chk++; if (lk_hit !== 1'b0) $display("FAIL alias_old_hit got %b want 0", lk_hit); else n_pass++;
    look(32'h140);
    n_chk++; if (lk_hit !== 1'b1) $display("FAIL alias_new_hit got %b want 1", lk_hit); else n_pass++;
    n_chk++; if (lk_target !== 32'h300) $display("FAIL alias_new_target got %h want 300", lk_target); else n_pass++;
    lk_en = 1'b0;
    upd(32'h104, 1'b0, 32'h400, 1'b0);            // allocate not-taken, ctr=1
    look(32'h104);
    n_chk++; if ({lk_hit, lk_taken} !== 2'b10) $display("FAIL alloc_nt_hit_taken got %b%b want 10", lk_hit, lk_taken); else n_pass++;
    n_chk++; if (lk_target !== 32'h400) $display("FAIL alloc_nt_target got %h want 400", lk_target); else n_pass++;
    lk_en = 1'b0;
  endtask

  task automatic test_same_cycle();
    upd(32'h100, 1'b0, 32'h80, 1'b0);             // replaces 0x140, ctr=1
    upd_en = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'hA0;
    look(32'h100);
    n_chk++; if (lk_taken !== 1'b0) $display("FAIL bypass_taken got %b want 0", lk_taken); else n_pass++;
    n_chk++; if (lk_target !== 32'h80) $display("FAIL bypass_target got %h want 80", lk_target); else n_pass++;
    step();
    upd_en = 1'b0;
    n_chk++; if (lk_taken !== 1'b1) $display("FAIL post_update_taken got %b want 1", lk_taken); else n_pass++;
    n_chk++; if (lk_target !== 32'hA0) $display("FAIL post_update_target got %h want a0", lk_target); else n_pass++;
    lk_en = 1'b0;
    flush = 1'b1;
    upd(32'h180, 1'b1, 32'h700, 1'b0);            // flush wins, no allocation
    flush = 1'b0;
    look(32'h100);
    n_chk++; if (lk_hit !== 1'b0) $display("FAIL flush_clears_hit got %b want 0", lk_hit); else n_pass++;
    look(32'h180);
    n_chk++; if (lk_hit !== 1'b0) $display("FAIL flush_blocks_alloc got %b want 0", lk_hit); else n_pass++;
    lk_en = 1'b0;
    step();
    look(32'h104);
    n_chk++; if (lk_hit !== 1'b0) $display("FAIL flush_other_index got %b want 0", lk_hit); else n_pass++;
    lk_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    upd(32'h1C0, 1'b1, 32'h55C, 1'b1);
    look(32'h1C0);
    n_chk++; if (lk_hit !== 1'b1) $display("FAIL pre_reset_hit got %b want 1", lk_hit); else n_pass++;
    upd_en = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1; upd_target = 32'h123;
    #1;
    rst = 1'b1;
    #1;
    n_chk++; if (lk_hit !== 1'b0) $display("FAIL in_reset_hit got %b want 0", lk_hit); else n_pass++;
    n_chk++; if (stat_lookups !== 32'd0) $display("FAIL in_reset_lookups got %0d want 0", stat_lookups); else n_pass++;
    n_chk++; if (stat_mispred !== 32'd0) $display("FAIL in_reset_mispred got %0d want 0", stat_mispred); else n_pass++;
    @(negedge clk);
    upd_en = 1'b0; lk_en = 1'b0; rst = 1'b0;
    exp_lk = 0; exp_mp = 0;
    look(32'h200);
    n_chk++; if (lk_hit !== 1'b0) $display("FAIL reset_discards_update got %b want 0", lk_hit); else n_pass++;
    lk_en = 1'b0;
    step();
  endtask

  task automatic test_stats();
    for (int i = 0; i < 8; i++) upd(32'h300 + 32'(i * 4), 1'b1, 32'h10, 1'b1);
    n_chk++; if (stat_mispred !== 32'd8) $display("FAIL mispred_count got %0d want 8", stat_mispred); else n_pass++;
    n_chk++; if (stat_lookups !== exp_lk) $display("FAIL lookup_count got %0d want %0d", stat_lookups, exp_lk); else n_pass++;
    force dut.stat_lookups = 32'hFFFF_FFFF;
    #1;
    release dut.stat_lookups;
    #1;
    n_chk++; if (stat_lookups !== 32'hFFFF_FFFF) $display("FAIL preload got %h want ffffffff", stat_lookups); else n_pass++;
    lk_en = 1'b1; lk_pc = 32'h0;
    step();
    lk_en = 1'b0;
    n_chk++; if (stat_lookups !== 32'd0) $display("FAIL lookup_wrap got %h want 0", stat_lookups); else n_pass++;
    n_chk++; if (stat_mispred !== 32'd8) $display("FAIL mispred_hold got %0d want 8", stat_mispred); else n_pass++;
  endtask

`ifdef BP_RAS_EN
  task automatic test_ras();
    lk_call = 1'b1;
    for (int i = 0; i < 9; i++) begin
      look(32'(i * 16));
      step();
    end
    lk_call = 1'b0;
    lk_ret  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      look(32'h1000);
      if (i < 8) begin
        n_chk++; if ({lk_hit, lk_taken} !== 2'b11) $display("FAIL ras_pop%0d_hit got %b%b want 11", i, lk_hit, lk_taken); else n_pass++;
        n_chk++; if (lk_target !== 32'h84 - 32'(i * 16)) $display("FAIL ras_pop%0d_target got %h want %h", i, lk_target, 32'h84 - 32'(i * 16)); else n_pass++;
      end else begin
        n_chk++; if (lk_hit !== 1'b0) $display("FAIL ras_empty_fallback got %b want 0", lk_hit); else n_pass++;
      end
      step();
    end
    lk_ret = 1'b0;
    lk_en  = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_counter();
    test_alias();
    test_same_cycle();
    test_reset_mid();
    test_stats();
`ifdef BP_RAS_EN
    test_ras();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/br_pred_table.md
BR_PRED_TABLE -- requirements
Module: br_pred_table

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: number of branch-table entries; power of two, minimum 4.
REQ-002 SHALL have parameter CTR_W, default 2: saturating-counter width; range 2..4.
REQ-003 SHALL have parameter ADDR_W, default 32: instruction address width.
REQ-004 SHALL have parameter RAS_DEPTH, default 8: return-stack depth; power of two; used only under BP_RAS_EN.
REQ-005 SHALL have ports: clk  in  1  clock; all state updates on the rising edge.
REQ-006 SHALL have ports: rst  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have ports: flush  in  1  synchronous clear of all valid bits.
REQ-008 SHALL have ports: lk_en  in  1  ID-stage lookup request.
REQ-009 SHALL have ports: lk_pc  in  ADDR_W  PC of the instruction being decoded.
REQ-010 SHALL have ports: lk_call  in  1  the looked-up instruction is a call (jal/jalr with rd=x1).
REQ-011 SHALL have ports: lk_ret  in  1  the looked-up instruction is a return (jalr x0,0(x1)).
REQ-012 SHALL have ports: lk_hit  out  1  lookup hit.
REQ-013 SHALL have ports: lk_taken  out  1  predicted taken.
REQ-014 SHALL have ports: lk_target  out  ADDR_W  predicted target.
REQ-015 SHALL have ports: upd_en  in  1  EX-stage branch resolution valid.
REQ-016 SHALL have ports: upd_pc  in  ADDR_W  PC of the resolved branch.
REQ-017 SHALL have ports: upd_taken  in  1  actual outcome.
REQ-018 SHALL have ports: upd_target  in  ADDR_W  actual target.
REQ-019 SHALL have ports: upd_mispred  in  1  the prediction was wrong.
REQ-020 SHALL have ports: stat_lookups  out  32  count of lookups.
REQ-021 SHALL have ports: stat_mispred  out  32  count of mispredictions.

Function
REQ-022 SHALL use index = pc[log2(ENTRIES)+1:2] and tag = pc[ADDR_W-1:log2(ENTRIES)+2]; each entry SHALL hold valid, tag, target and a CTR_W-bit counter.
REQ-023 Lookup SHALL be combinational, with zero latency: lk_hit = lk_en & valid & tag match; lk_taken = lk_hit & counter MSB; lk_target = stored target when lk_hit, else 0.
REQ-024 With lk_en=0, all lk_* outputs SHALL be 0.
REQ-025 On upd_en to a hit entry, the counter SHALL increment if upd_taken and decrement otherwise, saturating at all-ones and at zero; the target SHALL be overwritten with upd_target when upd_taken.
REQ-026 On upd_en to a miss entry, the entry SHALL be allocated and the old entry replaced: valid=1, tag written, target written; the counter SHALL be set to 2^(CTR_W-1) (weakly taken) if upd_taken, else 2^(CTR_W-1)-1 (weakly not taken).
REQ-027 When a lookup and an update hit the same index in the same cycle, the lookup SHALL see the pre-update contents; there is no bypass.
REQ-028 flush SHALL clear all valid bits on the next edge; counters and targets SHALL be retained; when flush and upd_en occur in the same cycle, flush SHALL win and no allocation is made.
REQ-029 stat_lookups SHALL increment on every edge with lk_en=1; stat_mispred SHALL increment on every edge with upd_en & upd_mispred; both SHALL wrap modulo 2^32 and SHALL be unaffected by flush.

Reset
REQ-030 While rst=1, the block SHALL clear all valid bits, set every counter to 2^(CTR_W-1)-1, zero all targets and tags, zero both stat counters, and empty the return stack (pointer 0, count 0).
REQ-031 Reset asserted mid-update SHALL discard that update; lk_* outputs SHALL be 0 during reset since no entry is valid.

Configuration
REQ-032 Macro BP_RAS_EN defined: the block SHALL include a RAS_DEPTH-entry return-address stack, with the following behaviour:
 - lk_en & lk_call SHALL push lk_pc+4 at the edge;
 - lk_en & lk_ret with a non-empty stack SHALL force lk_hit=1, lk_taken=1 and lk_target=top, and SHALL pop at the edge;
 - a return with an empty stack SHALL fall back to table lookup;
 - a push when full SHALL overwrite the oldest entry (pointer wraps, count saturates at RAS_DEPTH);
 - lk_call & lk_ret together SHALL pop and then push, so the top is replaced;
 - flush SHALL empty the stack.
REQ-033 Macro BP_RAS_EN undefined: the block SHALL contain no stack logic, lk_call and lk_ret SHALL be ignored, and all predictions SHALL come from the table.

Verification
REQ-034 Reset, then lk_en=1, lk_pc=0x100 -> lk_hit=0, lk_taken=0, lk_target=0; stat_lookups=1 after the edge.
REQ-035 Update pc=0x100, taken, target=0x80; then lookup 0x100 -> hit=1, taken=1, target=0x80. Then two not-taken updates -> counter goes 2→1→0 and lookup gives taken=0; a third not-taken update leaves the counter at 0.
REQ-036 Update pc=0x100 and then pc=0x140 (same index when ENTRIES=16), both taken -> lookup of 0x100 misses and lookup of 0x140 hits with its own target.
REQ-037 Same-cycle lookup and update of 0x100 when the counter is 1 and the update is taken -> the lookup shows taken=0 that cycle and taken=1 the next cycle; flush asserted together with an update -> the next lookup misses.
REQ-038 BP_RAS_EN, RAS_DEPTH=8: nine calls from pc=0x0,0x10,...,0x80, then nine returns -> the first eight returns predict 0x84,0x74,...,0x14 and the ninth falls back to the table (miss).
REQ-039 Eight upd_mispred pulses plus 2^32-1 preloaded lookups (by force) -> stat_mispred=8 and stat_lookups wraps to 0 after one more lookup.
